risc16_mem_sys: RTL and testbench

RISC16_MEM_SYS -- requirements
Module: risc16_mem_sys

---
 rtl/risc16_mem_sys.sv | 136 +++++++++++++
 tb/tb_risc16_mem_sys.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/risc16_mem_sys.sv
// RISC16 memory subsystem: byte-addressed big-endian RAM, output registers,
// wait-state handshake and a sticky access-error flag.
module risc16_mem_sys #(
  parameter int          MEM_BYTES   = 1024,
  parameter logic [15:0] IO_BASE     = 16'h0200,
  parameter int          NUM_OUT     = 2,
  parameter int          WAIT_CYCLES = 0,
  parameter              INIT_FILE   = ""
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          addr,
  input  logic [15:0]          wdata,
  input  logic                 oe,
  input  logic                 we,
  output logic [15:0]          rdata,
  output logic                 ready,
  output logic [16*NUM_OUT-1:0] led,
  output logic                 err
);

  localparam int AW = ($clog2(MEM_BYTES) < 2) ? 2 : $clog2(MEM_BYTES);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]    state;
  logic [0:0]    state_nx;
  logic [2:0]    cnt;
  logic [2:0]    cnt_nx;
  logic          req;
  logic          io_hit;
  logic          ram_hit;
  logic          done;
  logic          wr;
  logic [14:0]   wofs;
  logic [15:0]   io_word;
  logic [AW-1:0] hi_idx;
  logic [AW-1:0] lo_idx;
  logic          unused_bit0;

  logic [7:0] mem [0:MEM_BYTES-1];

  assign unused_bit0 = addr[0];
  assign req     = oe | we;
  assign wofs    = addr[15:1] - IO_BASE[15:1];
  assign io_hit  = (addr[15:1] >= IO_BASE[15:1]) &&
                   (wofs < 15'(NUM_OUT));
  assign ram_hit = !io_hit &&
                   ({1'b0, addr[15:1], 1'b0} < 17'(MEM_BYTES));
  assign hi_idx  = {addr[AW-1:1], 1'b0};
  assign lo_idx  = {addr[AW-1:1], 1'b1};
  // an edge only completes an access while reset is released
  assign done    = ready & rst;
  assign wr      = done & we;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ready    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            ready = 1'b1;
          end else begin
            state_nx = WAIT;
            cnt_nx   = 3'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_nx = IDLE;
          cnt_nx   = 3'd0;
        end else if (cnt == 3'd0) begin
          ready    = 1'b1;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - 3'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 3'd0;
      end
    endcase
  end

  always_comb begin
    io_word = 16'h0000;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (wofs == 15'(i)) io_word = led[16*i +: 16];
    end
  end

  always_comb begin
    rdata = 16'h0000;
    if (oe && !we && ready) begin
      unique case (1'b1)
        io_hit:  rdata = io_word;
        ram_hit: rdata = {mem[hi_idx], mem[lo_idx]};
        default: rdata = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
      led   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (wr && io_hit) begin
        for (int i = 0; i < NUM_OUT; i++) begin
          if (wofs == 15'(i)) led[16*i +: 16] <= wdata;
        end
      end
      if (done && ((oe && we) || (!io_hit && !ram_hit))) begin
        err <= 1'b1;
      end
    end
  end

  // RAM has no reset so its contents survive rst
  always_ff @(posedge clk) begin
    if (wr && ram_hit) begin
      mem[hi_idx] <= wdata[15:8];
      mem[lo_idx] <= wdata[7:0];
    end
  end

endmodule

// File: tb/tb_risc16_mem_sys.sv
// Bench for risc16_mem_sys: three instances (0, 2, 3 wait states) driven
// with directed and random accesses against a byte-level reference model.
module tb_risc16_mem_sys;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr  [3];
  logic [15:0] wdata [3];
  logic        oe    [3];
  logic        we    [3];
  logic [15:0] rdata [3];
  logic        ready [3];
  logic [31:0] led   [3];
  logic        err   [3];

  int errors = 0;
  int checks = 0;
  int wc [3] = '{0, 2, 3};

  logic [7:0]  m_mem [3][0:1023];
  logic [15:0] m_led [3][2];
  logic        m_err [3];

  always #5 clk = ~clk;

  risc16_mem_sys #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .addr(addr[0]), .wdata(wdata[0]),
    .oe(oe[0]), .we(we[0]), .rdata(rdata[0]), .ready(ready[0]),
    .led(led[0]), .err(err[0]));

  risc16_mem_sys #(.WAIT_CYCLES(2)) u_dut1 (
    .clk(clk), .rst(rst), .addr(addr[1]), .wdata(wdata[1]),
    .oe(oe[1]), .we(we[1]), .rdata(rdata[1]), .ready(ready[1]),
    .led(led[1]), .err(err[1]));

  risc16_mem_sys #(.WAIT_CYCLES(3)) u_dut2 (
    .clk(clk), .rst(rst), .addr(addr[2]), .wdata(wdata[2]),
    .oe(oe[2]), .we(we[2]), .rdata(rdata[2]), .ready(ready[2]),
    .led(led[2]), .err(err[2]));

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference: decode by address range, big-endian byte store
  task automatic model(int d, logic [15:0] a, logic [15:0] wd,
                       logic o, logic w, output logic [15:0] r);
    int  ba;
    bit  io;
    bit  ram;
    ba  = int'(a) & 'hFFFE;
    io  = (ba >= 'h200) && (ba < 'h204);
    ram = !io && (ba < 1024);
    r   = 16'h0000;
    if (o && !w) begin
      if (io) r = m_led[d][(ba - 'h200) / 2];
      else if (ram) r = {m_mem[d][ba], m_mem[d][ba+1]};
    end
    if (w) begin
      if (io) m_led[d][(ba - 'h200) / 2] = wd;
      else if (ram) begin
        m_mem[d][ba]   = wd[15:8];
        m_mem[d][ba+1] = wd[7:0];
      end
    end
    if ((o && w) || (!io && !ram)) m_err[d] = 1'b1;
  endtask

  task automatic bus(int d, logic [15:0] a, logic [15:0] wd,
                     logic o, logic w,
                     output logic [15:0] rd, output int lat);
    @(negedge clk);
    addr[d] = a; wdata[d] = wd; oe[d] = o; we[d] = w;
    lat = 0;
    forever begin
      #1;
      if (ready[d] === 1'b1) break;
      if (lat >= 20) begin
        check($sformatf("d%0d_timeout", d), 32'(ready[d]), 1);
        break;
      end
      @(negedge clk);
      lat++;
    end
    rd = rdata[d];
    @(posedge clk);
    #1;
    oe[d] = 1'b0; we[d] = 1'b0;
  endtask

  task automatic xfer(int d, logic [15:0] a, logic [15:0] wd,
                      logic o, logic w, output logic [15:0] rd);
    logic [15:0] exp;
    int          lat;
    bus(d, a, wd, o, w, rd, lat);
    model(d, a, wd, o, w, exp);
    check($sformatf("d%0d_rdata@%h", d, a), 32'(rd), 32'(exp));
    check($sformatf("d%0d_lat", d), 32'(lat), 32'(wc[d]));
    check($sformatf("d%0d_led", d), led[d], {m_led[d][1], m_led[d][0]});
    check($sformatf("d%0d_err", d), 32'(err[d]), 32'(m_err[d]));
  endtask

  task automatic check_idle(string tag);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s_led%0d", tag, d), led[d],
            {m_led[d][1], m_led[d][0]});
      check($sformatf("%s_err%0d", tag, d), 32'(err[d]), 32'(m_err[d]));
      check($sformatf("%s_rdata%0d", tag, d), 32'(rdata[d]), 0);
    end
  endtask

  function automatic logic [15:0] pick_addr();
    case ($urandom_range(0, 9))
      5:       return 16'($urandom_range('h204, 'h207));
      6:       return 16'($urandom_range('h3FE, 'h3FF));
      7, 8:    return 16'($urandom_range('h200, 'h203));
      9:       return 16'($urandom_range('h400, 'hFFFF));
      default: return 16'($urandom_range(0, 'h47));
    endcase
  endfunction

  initial begin
    logic [15:0] rd;
    int          mode;
    for (int d = 0; d < 3; d++) begin
      addr[d] = 16'h0; wdata[d] = 16'h0; oe[d] = 1'b0; we[d] = 1'b0;
      m_led[d][0] = 16'h0; m_led[d][1] = 16'h0; m_err[d] = 1'b0;
    end
    rst = 1'b0;
    #1;
    check_idle("reset");
    repeat (3) @(negedge clk);
    rst = 1'b1;

    for (int d = 0; d < 3; d++) begin
      for (int a = 0; a < 'h48; a += 2)
        xfer(d, 16'(a), 16'($urandom), 1'b0, 1'b1, rd);
      xfer(d, 16'h0204, 16'($urandom), 1'b0, 1'b1, rd);
      xfer(d, 16'h0206, 16'($urandom), 1'b0, 1'b1, rd);
      xfer(d, 16'h03FE, 16'($urandom), 1'b0, 1'b1, rd);
    end

    xfer(0, 16'h0010, 16'hABCD, 1'b0, 1'b1, rd);
    xfer(0, 16'h0011, 16'h0000, 1'b1, 1'b0, rd);
    check("be_read", 32'(rd), 32'hABCD);

    xfer(2, 16'h0004, 16'h4321, 1'b0, 1'b1, rd);
    xfer(2, 16'h0004, 16'h0000, 1'b1, 1'b0, rd);
    check("wait3_read", 32'(rd), 32'h4321);

    for (int d = 0; d < 2; d++) begin
      xfer(d, 16'h0200, 16'h1234, 1'b0, 1'b1, rd);
      xfer(d, 16'h0202, 16'h00FF, 1'b0, 1'b1, rd);
      check($sformatf("led_cat%0d", d), led[d], 32'h00FF_1234);
      xfer(d, 16'h0202, 16'h0000, 1'b1, 1'b0, rd);
      check($sformatf("io_read%0d", d), 32'(rd), 32'h00FF);
    end

    xfer(0, 16'hF000, 16'h5555, 1'b0, 1'b1, rd);
    check("unmap_err", 32'(err[0]), 1);
    xfer(0, 16'hF000, 16'h0000, 1'b1, 1'b0, rd);
    check("unmap_rd", 32'(rd), 0);
    xfer(0, 16'h0010, 16'h0000, 1'b1, 1'b0, rd);

    xfer(1, 16'h0020, 16'h0F0F, 1'b1, 1'b1, rd);
    check("both_rd", 32'(rd), 0);
    check("both_err", 32'(err[1]), 1);
    xfer(1, 16'h0020, 16'h0000, 1'b1, 1'b0, rd);
    check("both_word", 32'(rd), 32'h0F0F);

    // abort: drop we part way through the wait
    @(negedge clk);
    addr[1] = 16'h0030; wdata[1] = 16'hDEAD; we[1] = 1'b1;
    @(negedge clk);
    #1;
    check("abort_rdy", 32'(ready[1]), 0);
    we[1] = 1'b0;
    @(negedge clk);
    xfer(1, 16'h0030, 16'h0000, 1'b1, 1'b0, rd);

    // reset during the wait of an IO write and of a RAM write
    xfer(2, 16'h0200, 16'h2468, 1'b0, 1'b1, rd);
    @(negedge clk);
    addr[2] = 16'h0202; wdata[2] = 16'h7777; we[2] = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      m_led[d][0] = 16'h0; m_led[d][1] = 16'h0; m_err[d] = 1'b0;
    end
    check_idle("rst_mid");
    we[2] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    addr[2] = 16'h0010; wdata[2] = 16'h9999; we[2] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    we[2] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    xfer(2, 16'h0010, 16'h0000, 1'b1, 1'b0, rd);
    xfer(2, 16'h0202, 16'h0000, 1'b1, 1'b0, rd);
    check("rst_io", 32'(rd), 0);

    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 60; n++) begin
        mode = $urandom_range(0, 9);
        xfer(d, pick_addr(), 16'($urandom),
             mode < 5 || mode == 9, mode >= 5, rd);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
